// File: rtl/game_seq_ctrl_if.sv
// rtl/game_seq_ctrl_if.sv - board/bird/pipe signal bundle for the game sequencer
//
// Groups the per-frame game inputs and the sequencer outputs.
// master: drives the game inputs and observes the outputs (board/bench side).
// slave : the sequencer itself.
//   i_Button       raw player button (asynchronous)
//   i_Frame_Start  one-cycle pulse per VGA frame
//   i_Bird_Dead    pulse, bird left the screen
//   i_Collide      level, bird overlaps a pipe
//   i_Pipe_Passed  one-cycle pulse, bird cleared a pipe
//   o_Start / o_Bounce / o_Bird_Reset  one-cycle control pulses
//   o_Pipe_En      level, pipes scroll
//   o_Score / o_High_Score  score counters
//   o_State        phase encoding
//   o_Game_Over    level, high in OVER
interface game_seq_ctrl_if #(
    parameter int SCORE_W = 10
);
    logic               i_Button;
    logic               i_Frame_Start;
    logic               i_Bird_Dead;
    logic               i_Collide;
    logic               i_Pipe_Passed;
    logic               o_Start;
    logic               o_Bounce;
    logic               o_Bird_Reset;
    logic               o_Pipe_En;
    logic [SCORE_W-1:0] o_Score;
    logic [SCORE_W-1:0] o_High_Score;
    logic [1:0]         o_State;
    logic               o_Game_Over;

    modport master (
        output i_Button, i_Frame_Start, i_Bird_Dead, i_Collide, i_Pipe_Passed,
        input  o_Start, o_Bounce, o_Bird_Reset, o_Pipe_En,
        input  o_Score, o_High_Score, o_State, o_Game_Over
    );

    modport slave (
        input  i_Button, i_Frame_Start, i_Bird_Dead, i_Collide, i_Pipe_Passed,
        output o_Start, o_Bounce, o_Bird_Reset, o_Pipe_En,
        output o_Score, o_High_Score, o_State, o_Game_Over
    );
endinterface

// File: rtl/game_seq_ctrl.sv
// rtl/game_seq_ctrl.sv - Flappy Bird game phase sequencer
//
// Owns the player button (synchronise, edge-detect, lockout) and the game
// phase IDLE -> PLAY -> DYING -> OVER -> IDLE. Generates start/bounce/reset
// pulses for the bird, pipe enable, score and optional high score.
// Ports:
//   i_Clk    pixel clock
//   i_Reset  asynchronous, active-high reset
//   bus      game_seq_ctrl_if.slave (game inputs, control/score outputs)
// Optional feature macro: GAME_SEQ_HIGH_SCORE_EN builds the high-score
// register; without it o_High_Score is tied to 0.
module game_seq_ctrl #(
    parameter int SCORE_W         = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEATH_FRAMES    = 60
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    game_seq_ctrl_if.slave bus
);
    localparam int LOCK_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FRAME_W = $clog2(DEATH_FRAMES + 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FRAME_END = FRAME_W'(DEATH_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Button path registers
    logic              sync1_q, sync2_q;
    logic              vld1_q, vld2_q;
    logic              prev_q, prev_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              press_q, press_d;
    logic              rise;

    // Game registers
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               start_q, start_d;
    logic               bounce_q, bounce_d;
    logic               brst_q, brst_d;
    logic               death;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;
`endif

    // The synchronizer stages come out of reset at 0 while prev_q starts at 1.
    // vld1_q/vld2_q mark when sync2_q holds a real button sample; until then
    // prev_q is frozen at 1, so a button held through reset never looks like
    // a rising edge and must be released and pressed again.
    always_comb begin
        rise    = vld2_q & sync2_q & ~prev_q;
        prev_d  = vld2_q ? sync2_q : prev_q;
        press_d = 1'b0;
        lock_d  = lock_q;
        if (rise && (lock_q == '0)) begin
            press_d = 1'b1;
            lock_d  = LOCK_LOAD;
        end else if (lock_q != '0) begin
            lock_d = lock_q - LOCK_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            prev_q  <= 1'b1;
            lock_q  <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= bus.i_Button;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            prev_q  <= prev_d;
            lock_q  <= lock_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        frame_d  = frame_q;
        start_d  = 1'b0;
        bounce_d = 1'b0;
        brst_d   = 1'b0;
        death    = bus.i_Bird_Dead | bus.i_Collide;
`ifdef GAME_SEQ_HIGH_SCORE_EN
        high_d   = high_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_q) begin
                    start_d = 1'b1;
                    score_d = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Death wins over a same-cycle pipe pass and flap.
                if (death) begin
                    state_d = ST_DYING;
                    frame_d = '0;
                end else begin
                    bounce_d = press_q;
                    if (bus.i_Pipe_Passed && (score_q != SCORE_MAX)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
            end
            ST_DYING: begin
                if (bus.i_Frame_Start) begin
                    frame_d = frame_q + FRAME_W'(1);
                    if (frame_d == FRAME_END) begin
                        state_d = ST_OVER;
`ifdef GAME_SEQ_HIGH_SCORE_EN
                        if (score_q > high_q) begin
                            high_d = score_q;
                        end
`endif
                    end
                end
            end
            ST_OVER: begin
                if (press_q) begin
                    brst_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            score_q  <= '0;
            frame_q  <= '0;
            start_q  <= 1'b0;
            bounce_q <= 1'b0;
            brst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            frame_q  <= frame_d;
            start_q  <= start_d;
            bounce_q <= bounce_d;
            brst_q   <= brst_d;
        end
    end

`ifdef GAME_SEQ_HIGH_SCORE_EN
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end
    assign bus.o_High_Score = high_q;
`else
    assign bus.o_High_Score = '0;
`endif

    assign bus.o_Start      = start_q;
    assign bus.o_Bounce     = bounce_q;
    assign bus.o_Bird_Reset = brst_q;
    assign bus.o_Pipe_En    = (state_q == ST_PLAY);
    assign bus.o_Game_Over  = (state_q == ST_OVER);
    assign bus.o_Score      = score_q;
    assign bus.o_State      = state_q;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb/tb_game_seq_ctrl.sv - self-checking bench for game_seq_ctrl
module tb_game_seq_ctrl;
    localparam int SW  = 3;
    localparam int DEB = 8;
    localparam int DF  = 3;
    localparam int SMAX = (1 << SW) - 1;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_seq_ctrl_if #(.SCORE_W(SW)) bus();

    game_seq_ctrl #(
        .SCORE_W(SW),
        .DEBOUNCE_CYCLES(DEB),
        .DEATH_FRAMES(DF)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: game phase as plain integers, presses as a queue of
    // cycle numbers at which they take effect.
    int m_state, m_score, m_high, m_frames;
    int m_start, m_bounce, m_brst;
    int cyc, last_btn, last_acc;
    int due[$];
    int cnt_start, cnt_bounce, cnt_brst;

    function automatic int hs_exp(input int v);
        return HS_EN ? v : 0;
    endfunction

    task automatic mdl_reset();
        m_state = 0; m_score = 0; m_high = 0; m_frames = 0;
        m_start = 0; m_bounce = 0; m_brst = 0;
        last_btn = 1;
        last_acc = -1000;
        due.delete();
    endtask

    task automatic mdl_step();
        bit press, b, death;
        cyc++;
        press = (due.size() > 0) && (due[0] == cyc);
        if (press) void'(due.pop_front());
        b = bus.i_Button;
        if (b && !last_btn && (cyc - last_acc >= DEB)) begin
            last_acc = cyc;
            due.push_back(cyc + 3);
        end
        last_btn = b;
        death = bus.i_Bird_Dead | bus.i_Collide;
        m_start = 0; m_bounce = 0; m_brst = 0;
        case (m_state)
            0: if (press) begin m_start = 1; m_score = 0; m_state = 1; end
            1: begin
                if (death) begin
                    m_state = 2; m_frames = 0;
                end else begin
                    if (press) m_bounce = 1;
                    if (bus.i_Pipe_Passed) m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                end
            end
            2: if (bus.i_Frame_Start) begin
                m_frames++;
                if (m_frames == DF) begin
                    m_state = 3;
                    if (m_score > m_high) m_high = m_score;
                end
            end
            default: if (press) begin m_brst = 1; m_state = 0; end
        endcase
    endtask

    task automatic compare_all();
        chk("state", int'(bus.o_State), m_state);
        chk("score", int'(bus.o_Score), m_score);
        chk("high", int'(bus.o_High_Score), hs_exp(m_high));
        chk("start", int'(bus.o_Start), m_start);
        chk("bounce", int'(bus.o_Bounce), m_bounce);
        chk("bird_reset", int'(bus.o_Bird_Reset), m_brst);
        chk("pipe_en", int'(bus.o_Pipe_En), (m_state == 1) ? 1 : 0);
        chk("game_over", int'(bus.o_Game_Over), (m_state == 3) ? 1 : 0);
        cnt_start  += int'(bus.o_Start);
        cnt_bounce += int'(bus.o_Bounce);
        cnt_brst   += int'(bus.o_Bird_Reset);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) mdl_step();
        @(negedge clk);
        compare_all();
        bus.i_Frame_Start = 1'b0;
        bus.i_Pipe_Passed = 1'b0;
        bus.i_Bird_Dead   = 1'b0;
        bus.i_Collide     = 1'b0;
    endtask

    task automatic do_press();
        bus.i_Button = 1'b1;
        repeat (3) tick();
        bus.i_Button = 1'b0;
        repeat (DEB + 2) tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_Frame_Start = 1'b1;
            tick();
        end
    endtask

    int s0, b0, r0;

    initial begin
        bus.i_Button = 1'b0; bus.i_Frame_Start = 1'b0; bus.i_Bird_Dead = 1'b0;
        bus.i_Collide = 1'b0; bus.i_Pipe_Passed = 1'b0;
        cyc = 0; cnt_start = 0; cnt_bounce = 0; cnt_brst = 0;
        mdl_reset();
        #1;
        compare_all();
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();

        // Start latency: output pulse after the 4th edge from first sample.
        bus.i_Button = 1'b1;
        repeat (3) tick();
        chk("t1_start_early", int'(bus.o_Start), 0);
        tick();
        chk("t1_start", int'(bus.o_Start), 1);
        chk("t1_state", int'(bus.o_State), 1);
        chk("t1_score", int'(bus.o_Score), 0);
        tick();
        chk("t1_start_width", int'(bus.o_Start), 0);
        bus.i_Button = 1'b0;
        repeat (DEB + 2) tick();

        // Lockout: second edge 4 clocks later ignored, third at 10 accepted.
        b0 = cnt_bounce;
        for (int i = 0; i < 17; i++) begin
            bus.i_Button = (i == 0 || i == 1 || i == 4 || i == 5 || i == 10 || i == 11);
            tick();
            if (i == 12) chk("t2_one_bounce", cnt_bounce - b0, 1);
        end
        chk("t2_two_bounce", cnt_bounce - b0, 2);
        bus.i_Button = 1'b0;
        repeat (DEB) tick();

        // Saturating score, then collide beats pipe pass.
        for (int i = 0; i < 9; i++) begin
            bus.i_Pipe_Passed = 1'b1;
            tick();
            tick();
        end
        chk("t3_sat", int'(bus.o_Score), SMAX);
        bus.i_Pipe_Passed = 1'b1;
        bus.i_Collide = 1'b1;
        tick();
        chk("t3_score_hold", int'(bus.o_Score), SMAX);
        chk("t3_dying", int'(bus.o_State), 2);
        chk("t3_pipe_off", int'(bus.o_Pipe_En), 0);

        // Death animation and high score.
        frames(2);
        chk("t4_still_dying", int'(bus.o_State), 2);
        frames(1);
        chk("t4_over", int'(bus.o_State), 3);
        chk("t4_game_over", int'(bus.o_Game_Over), 1);
        chk("t4_high", int'(bus.o_High_Score), hs_exp(SMAX));

        // OVER -> IDLE keeps score; next press clears it.
        r0 = cnt_brst;
        do_press();
        chk("t5_brst", cnt_brst - r0, 1);
        chk("t5_idle", int'(bus.o_State), 0);
        chk("t5_score_kept", int'(bus.o_Score), SMAX);
        s0 = cnt_start;
        do_press();
        chk("t5_start", cnt_start - s0, 1);
        chk("t5_score_clr", int'(bus.o_Score), 0);

        // Lower second game leaves high score alone.
        for (int i = 0; i < 4; i++) begin
            bus.i_Pipe_Passed = 1'b1;
            tick();
        end
        bus.i_Bird_Dead = 1'b1;
        tick();
        frames(DF);
        chk("t4b_score", int'(bus.o_Score), 4);
        chk("t4b_high", int'(bus.o_High_Score), hs_exp(SMAX));

        // Reset in DYING with button held.
        do_press();
        do_press();
        bus.i_Collide = 1'b1;
        tick();
        chk("t6_dying", int'(bus.o_State), 2);
        bus.i_Button = 1'b1;
        rst = 1'b1;
        mdl_reset();
        #1;
        compare_all();
        repeat (3) tick();
        rst = 1'b0;
        s0 = cnt_start;
        repeat (20) tick();
        chk("t6_no_start", cnt_start - s0, 0);
        bus.i_Button = 1'b0;
        repeat (3) tick();
        bus.i_Button = 1'b1;
        repeat (6) tick();
        chk("t6_start", cnt_start - s0, 1);
        bus.i_Button = 1'b0;
        repeat (DEB) tick();

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.i_Button = ~bus.i_Button;
            bus.i_Frame_Start = ($urandom_range(0, 4) == 0);
            bus.i_Pipe_Passed = ($urandom_range(0, 6) == 0);
            bus.i_Collide     = ($urandom_range(0, 49) == 0);
            bus.i_Bird_Dead   = ($urandom_range(0, 89) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/game_seq_ctrl.md
Name: game_seq_ctrl

Overview:
Top-level game sequencer for Flappy Bird. It owns the player button and the game phase, and generates the start, bounce and restart controls for the bird controller and the pipe-enable for the pipe generator. It counts the score from pipe-pass events and sequences death, a timed death animation, game-over and restart. It sits between the board I/O and the bird/pipe blocks, clocked on the VGA pixel clock.

Parameters:
- SCORE_W, 10: width of the score and high-score counters.
- DEBOUNCE_CYCLES, 250000: lockout in clocks after an accepted button press (10 ms at 25 MHz).
- DEATH_FRAMES, 60: number of i_Frame_Start pulses spent in DYING.

Ports:
- i_Clk, in, 1: pixel clock.
- i_Reset, in, 1: reset, asynchronous, active-high.
- i_Button, in, 1: raw player button, asynchronous, active-high.
- i_Frame_Start, in, 1: one-cycle pulse at the start of each VGA frame.
- i_Bird_Dead, in, 1: pulse from the bird controller when the bird leaves the screen.
- i_Collide, in, 1: level from the pipe block; bird overlaps a pipe.
- i_Pipe_Passed, in, 1: one-cycle pulse when the bird clears a pipe.
- o_Start, out, 1: one-cycle pulse; bird begins falling.
- o_Bounce, out, 1: one-cycle pulse; bird flap.
- o_Bird_Reset, out, 1: one-cycle pulse; returns the bird and pipes to their initial state.
- o_Pipe_En, out, 1: level; pipes scroll.
- o_Score, out, SCORE_W: current score.
- o_High_Score, out, SCORE_W: best score since reset.
- o_State, out, 2: current state encoding.
- o_Game_Over, out, 1: level; high in OVER.

Behaviour:
- Reset: state IDLE. All pulse outputs 0. o_Pipe_En=0, o_Score=0, o_High_Score=0, o_Game_Over=0. Synchronizer, lockout counter and frame counter all 0.
- Button path:
  - 2-FF synchronizer, then a rising-edge detector.
  - An edge is accepted only when the lockout counter is 0. Acceptance loads the counter with DEBOUNCE_CYCLES-1, which then decrements to 0.
  - An accepted press is called "press".
- Pulse outputs are registered and at most one cycle wide. A button rising edge first sampled at clock edge k produces its output pulse high after edge k+3, for exactly one cycle.
- States (o_State): IDLE=0, PLAY=1, DYING=2, OVER=3.
- IDLE:
  - press: o_Start pulse, o_Score cleared to 0, go to PLAY.
  - i_Bird_Dead, i_Collide and i_Pipe_Passed are ignored.
- PLAY:
  - o_Pipe_En=1.
  - press: o_Bounce pulse.
  - i_Pipe_Passed: o_Score+1, saturating at 2^SCORE_W-1.
  - i_Bird_Dead or i_Collide: go to DYING and clear the frame counter.
  - If a collision/death and i_Pipe_Passed arrive in the same cycle, the collision wins and the score is not incremented.
  - If a press and a death arrive in the same cycle, o_Bounce is suppressed.
- DYING:
  - o_Pipe_En=0. Presses are ignored, but the lockout counter still runs.
  - Each i_Frame_Start increments the frame counter.
  - On the pulse that brings the count to DEATH_FRAMES, go to OVER. On that transition, if o_Score > o_High_Score, load o_High_Score from o_Score.
- OVER:
  - o_Game_Over=1.
  - press: o_Bird_Reset pulse, go to IDLE. o_Score is held until the next o_Start.
- Illegal state: go to IDLE on the next clock.
- Reset asserted mid-game: all registers return to reset values immediately. A button held through reset deassertion produces no press until it is released and pressed again. The synchronizer resets to 0 and the edge detector's previous-value register resets to 1.

Optional Feature:
GAME_SEQ_HIGH_SCORE_EN
- Defined: the high-score register and update rule are as specified above.
- Undefined: no high-score register is built, o_High_Score is tied to 0, and the OVER transition does no compare.

Test Plan:
1. DEBOUNCE_CYCLES=8. Raise i_Button at edge 10 → o_Start high for one cycle after edge 13; state=PLAY; o_Score=0.
2. In PLAY, press twice 4 clocks apart (both within the lockout) → exactly one o_Bounce pulse. Press again 10 clocks after the first press → second o_Bounce.
3. SCORE_W=3: 9 i_Pipe_Passed pulses → o_Score stops at 7. i_Pipe_Passed together with i_Collide in the same cycle → o_Score unchanged, state=DYING, o_Pipe_En=0 next cycle.
4. DEATH_FRAMES=3 with o_Score=5, high=2 → OVER on the 3rd i_Frame_Start; o_High_Score=5, o_Game_Over=1. Next game ending at score 4 → high stays 5.
5. In OVER, press → o_Bird_Reset pulse, IDLE, o_Score still 4. Next press → o_Start, o_Score=0.
6. Assert i_Reset in DYING with i_Button held → all outputs at reset values. After release, no o_Start until the button is released and pressed again.
